// File: rtl/kmac_pkg.sv
// Shared constants and the byte-level padding merge used by kmac_msgpad.
// The merge builds one Keccak input word from a (possibly partial) message word.
package kmac_pkg;

    localparam int MsgWidth     = 64;
    localparam int StrbWidth    = MsgWidth / 8;
    localparam int MaxRateWords = 21;

    localparam logic [7:0] PadEnd = 8'h80;

    // Keep the first n bytes (n = trailing ones of strb), put pad_byte at byte n,
    // zero the rest, and OR 0x80 into the top byte when this is the last rate word.
    function automatic logic [MsgWidth-1:0] pad_merge(
        input logic [MsgWidth-1:0]  data,
        input logic [StrbWidth-1:0] strb,
        input logic [7:0]           pad_byte,
        input logic                 is_last
    );
        logic [MsgWidth-1:0] word;
        int                  n;
        word = '0;
        n    = 0;
        for (int i = 0; i < StrbWidth; i++) begin
            if (strb[i] && (n == i)) n = i + 1;
        end
        for (int i = 0; i < StrbWidth; i++) begin
            if (i < n)       word[8*i +: 8] = data[8*i +: 8];
            else if (i == n) word[8*i +: 8] = pad_byte;
        end
        if (is_last) word[MsgWidth-1 -: 8] = word[MsgWidth-1 -: 8] | PadEnd;
        return word;
    endfunction

endpackage

// File: rtl/kmac_msgpad.sv
// Absorbs message words into the Keccak state at rate-block addresses and
// applies SHA3/SHAKE multi-rate padding, requesting one permutation per block.
module kmac_msgpad #(
    parameter int MsgWidth     = kmac_pkg::MsgWidth,
    parameter int MaxRateWords = kmac_pkg::MaxRateWords
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [4:0]            rate_words_i,
    input  logic [7:0]            pad_byte_i,
    input  logic                  process_i,
    input  logic                  clear_i,
    input  logic                  msg_valid_i,
    input  logic [MsgWidth-1:0]   msg_data_i,
    input  logic [MsgWidth/8-1:0] msg_strb_i,
    output logic                  msg_ready_o,
    output logic                  keccak_valid_o,
    output logic [4:0]            keccak_addr_o,
    output logic [MsgWidth-1:0]   keccak_data_o,
    input  logic                  keccak_ready_i,
    output logic                  run_o,
    input  logic                  run_ack_i,
    output logic                  absorbed_o,
    output logic                  busy_o
);
    import kmac_pkg::*;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StAbsorb  = 3'd1,
        StPad     = 3'd2,
        StRun     = 3'd3,
        StRunLast = 3'd4
    } state_e;

    localparam logic [4:0] MaxRate = 5'(MaxRateWords);

    state_e     state_q, state_d;
    logic [4:0] word_cnt_q, word_cnt_d;
    logic [4:0] rate_q;
    logic [7:0] pad_q;
    logic       process_q;
    logic       pad_due_q, pad_due_d;
    logic       run_first_q;

    logic last_word;
    logic msg_full;
    logic msg_accept;
    logic ack_ok;

    assign last_word  = (word_cnt_q == rate_q - 5'd1);
    assign msg_full   = &msg_strb_i;
    assign msg_accept = msg_valid_i && keccak_ready_i;
    // The acknowledge is only honoured once run_o has been presented for a cycle.
    assign ack_ok     = run_ack_i && !run_first_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its peers, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            word_cnt_q  <= '0;
            rate_q      <= MaxRate;
            pad_q       <= '0;
            process_q   <= 1'b0;
            pad_due_q   <= 1'b0;
            run_first_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            pad_due_q  <= pad_due_d;
            run_first_q <= ((state_d == StRun) || (state_d == StRunLast)) &&
                           (state_d != state_q);
            if ((state_q == StIdle) && start_i && !clear_i) begin
                rate_q <= ((rate_words_i == 5'd0) || (rate_words_i > MaxRate)) ?
                          MaxRate : rate_words_i;
                pad_q  <= pad_byte_i;
            end
            if (state_d == StIdle)                      process_q <= 1'b0;
            else if (process_i && (state_q != StIdle))  process_q <= 1'b1;
        end
    end

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        pad_due_d  = pad_due_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) state_d = StAbsorb;
            end
            StAbsorb: begin
                if (msg_accept) begin
                    if (msg_full) begin
                        if (last_word) state_d = StRun;
                        else           word_cnt_d = word_cnt_q + 5'd1;
                    end else if (last_word) begin
                        state_d = StRunLast;
                    end else begin
                        state_d    = StPad;
                        word_cnt_d = word_cnt_q + 5'd1;
                    end
                end else if (process_q && !msg_valid_i) begin
                    // Message ended on a word boundary: the pad byte opens the next word.
                    state_d   = StPad;
                    pad_due_d = 1'b1;
                end
            end
            StPad: begin
                if (keccak_ready_i) begin
                    pad_due_d = 1'b0;
                    if (last_word) state_d = StRunLast;
                    else           word_cnt_d = word_cnt_q + 5'd1;
                end
            end
            StRun: begin
                if (ack_ok) begin
                    state_d    = StAbsorb;
                    word_cnt_d = '0;
                end
            end
            StRunLast: begin
                if (ack_ok) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (clear_i) state_d = StIdle;
        if (state_d == StIdle) begin
            word_cnt_d = '0;
            pad_due_d  = 1'b0;
        end
    end

    always_comb begin
        msg_ready_o    = 1'b0;
        keccak_valid_o = 1'b0;
        keccak_data_o  = '0;
        run_o          = 1'b0;
        absorbed_o     = 1'b0;
        unique case (state_q)
            StAbsorb: begin
                keccak_valid_o = msg_valid_i;
                msg_ready_o    = keccak_ready_i;
                keccak_data_o  = pad_merge(msg_data_i, msg_strb_i, pad_q,
                                           last_word && !msg_full);
            end
            StPad: begin
                keccak_valid_o = 1'b1;
                keccak_data_o  = pad_merge('0, '0, pad_due_q ? pad_q : 8'h00, last_word);
            end
            StRun: begin
                run_o = run_first_q;
            end
            StRunLast: begin
                run_o      = run_first_q;
                absorbed_o = ack_ok && !clear_i;
            end
            default: ;
        endcase
    end

    assign keccak_addr_o = word_cnt_q;
    assign busy_o        = (state_q != StIdle);

endmodule

// File: tb/tb_kmac_msgpad.sv
// Self-checking bench for kmac_msgpad: directed and random messages compared
// against a byte-level padding model, with backpressure and delayed acks.
module tb_kmac_msgpad;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [4:0]  rate_words_i = '0;
    logic [7:0]  pad_byte_i = '0;
    logic        process_i = 1'b0;
    logic        clear_i = 1'b0;
    logic        msg_valid_i = 1'b0;
    logic [63:0] msg_data_i = '0;
    logic [7:0]  msg_strb_i = '0;
    logic        msg_ready_o;
    logic        keccak_valid_o;
    logic [4:0]  keccak_addr_o;
    logic [63:0] keccak_data_o;
    logic        keccak_ready_i = 1'b1;
    logic        run_o;
    logic        run_ack_i = 1'b0;
    logic        absorbed_o;
    logic        busy_o;

    kmac_msgpad dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .rate_words_i   (rate_words_i),
        .pad_byte_i     (pad_byte_i),
        .process_i      (process_i),
        .clear_i        (clear_i),
        .msg_valid_i    (msg_valid_i),
        .msg_data_i     (msg_data_i),
        .msg_strb_i     (msg_strb_i),
        .msg_ready_o    (msg_ready_o),
        .keccak_valid_o (keccak_valid_o),
        .keccak_addr_o  (keccak_addr_o),
        .keccak_data_o  (keccak_data_o),
        .keccak_ready_i (keccak_ready_i),
        .run_o          (run_o),
        .run_ack_i      (run_ack_i),
        .absorbed_o     (absorbed_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        assert (got === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Environment knobs driven by the main sequence.
    int  rdy_mode = 0;   // 0: always ready, 1: random, 2: never ready
    int  ack_mode = 0;   // 0: ack after random 0..30 extra cycles, 1: ack tied high
    bit  mon_en   = 1'b1;

    // Observed traffic.
    logic [63:0] wr_data[$];
    logic [4:0]  wr_addr[$];
    int          run_cnt = 0;
    int          abs_cnt = 0;
    longint      cyc = 0;
    longint      last_run_cyc = -1;

    // Reference model output.
    logic [7:0]  msg_b[512];
    logic [63:0] exp_data[$];
    logic [4:0]  exp_addr[$];
    int          exp_blocks;

    initial begin
        forever begin
            @(posedge clk_i); #1;
            case (rdy_mode)
                0:       keccak_ready_i = 1'b1;
                1:       keccak_ready_i = ($urandom_range(0, 3) != 0);
                default: keccak_ready_i = 1'b0;
            endcase
        end
    end

    initial begin
        int ack_cnt = 0;
        forever begin
            @(posedge clk_i); #1;
            if (ack_mode == 1) begin
                run_ack_i = 1'b1;
            end else if (run_o) begin
                ack_cnt   = $urandom_range(0, 30) + 1;
                run_ack_i = 1'b0;
            end else if (ack_cnt > 0) begin
                ack_cnt--;
                run_ack_i = (ack_cnt == 0);
            end else begin
                run_ack_i = 1'b0;
            end
        end
    end

    initial begin
        bit          prev_stall = 1'b0;
        bit          prev_run   = 1'b0;
        logic [4:0]  prev_addr  = '0;
        logic [63:0] prev_data  = '0;
        forever begin
            @(negedge clk_i);
            cyc++;
            if (mon_en) begin
                if (prev_stall) begin
                    check("stall_valid", 64'(keccak_valid_o), 64'd1);
                    check("stall_addr",  64'(keccak_addr_o), 64'(prev_addr));
                    check("stall_data",  keccak_data_o, prev_data);
                end
                if (keccak_valid_o && keccak_ready_i) begin
                    wr_data.push_back(keccak_data_o);
                    wr_addr.push_back(keccak_addr_o);
                end
                if (run_o) begin
                    run_cnt++;
                    check("run_single_cycle", 64'(prev_run), 64'd0);
                    last_run_cyc = cyc;
                end
                if (absorbed_o) begin
                    abs_cnt++;
                    check("absorb_after_run", 64'(cyc > last_run_cyc), 64'd1);
                end
                prev_stall = keccak_valid_o && !keccak_ready_i;
                prev_run   = run_o;
                prev_addr  = keccak_addr_o;
                prev_data  = keccak_data_o;
            end else begin
                prev_stall = 1'b0;
                prev_run   = 1'b0;
            end
        end
    end

    // Padded byte stream: message, pad byte, zeros, 0x80 OR-ed into the final byte.
    task automatic build_expected(input int r, input logic [7:0] pad, input int len);
        int blk_bytes;
        int total;
        blk_bytes  = r * 8;
        exp_blocks = len / blk_bytes + 1;
        total      = exp_blocks * blk_bytes;
        exp_data.delete();
        exp_addr.delete();
        for (int j = 0; j < total / 8; j++) begin
            logic [63:0] w;
            w = '0;
            for (int k = 0; k < 8; k++) begin
                int          i;
                logic [7:0]  b;
                i = 8 * j + k;
                if (i < len)       b = msg_b[i];
                else if (i == len) b = pad;
                else               b = 8'h00;
                if (i == total - 1) b = b | 8'h80;
                w[8*k +: 8] = b;
            end
            exp_data.push_back(w);
            exp_addr.push_back(5'(j % r));
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},   64'(busy_o), 64'd0);
        check({tag, "_valid"},  64'(keccak_valid_o), 64'd0);
        check({tag, "_ready"},  64'(msg_ready_o), 64'd0);
        check({tag, "_addr"},   64'(keccak_addr_o), 64'd0);
        check({tag, "_data"},   keccak_data_o, 64'd0);
        check({tag, "_run"},    64'(run_o), 64'd0);
        check({tag, "_absorb"}, 64'(absorbed_o), 64'd0);
    endtask

    // Runs one message; entered and left at a negedge.
    task automatic run_msg(input int rate_cfg, input int eff_rate, input logic [7:0] pad,
                           input int len, input bit proc_late, input bit start_noise);
        int nwords;
        int t;
        bit acc;
        nwords = (len + 7) / 8;
        build_expected(eff_rate, pad, len);
        wr_data.delete();
        wr_addr.delete();
        run_cnt = 0;
        abs_cnt = 0;

        @(posedge clk_i); #1;
        start_i      = 1'b1;
        rate_words_i = 5'(rate_cfg);
        pad_byte_i   = pad;
        @(posedge clk_i); #1;
        start_i      = 1'b0;
        rate_words_i = 5'($urandom_range(0, 31));
        pad_byte_i   = 8'($urandom);

        for (int w = 0; w < nwords; w++) begin
            int n;
            n = (len - 8 * w >= 8) ? 8 : len - 8 * w;
            for (int k = 0; k < 8; k++)
                msg_data_i[8*k +: 8] = (k < n) ? msg_b[8*w + k] : 8'($urandom);
            msg_strb_i  = 8'((16'd1 << n) - 16'd1);
            msg_valid_i = 1'b1;
            if ((w == nwords - 1) && !proc_late) process_i = 1'b1;
            if (start_noise && (w == 0)) begin
                start_i      = 1'b1;
                rate_words_i = 5'($urandom_range(1, 21));
            end
            t = 0;
            do begin
                @(negedge clk_i);
                acc = msg_ready_o;
                @(posedge clk_i); #1;
                process_i = 1'b0;
                start_i   = 1'b0;
                t++;
            end while (!acc && (t < 2000));
            if (!acc) check("word_accept", 64'(acc), 64'd1);
        end
        msg_valid_i = 1'b0;
        msg_strb_i  = '0;
        if (proc_late || (nwords == 0)) begin
            repeat ($urandom_range(0, 5)) @(posedge clk_i);
            #1 process_i = 1'b1;
            @(posedge clk_i); #1 process_i = 1'b0;
        end

        t = 0;
        while ((abs_cnt == 0) && (t < 5000)) begin
            @(negedge clk_i);
            t++;
        end
        check("absorbed_seen", 64'(abs_cnt > 0), 64'd1);
        @(negedge clk_i);
        check("busy_after_absorb", 64'(busy_o), 64'd0);
        check("absorbed_once", 64'(abs_cnt), 64'd1);
        check("run_pulses", 64'(run_cnt), 64'(exp_blocks));
        check("write_count", 64'(wr_data.size()), 64'(exp_data.size()));
        for (int i = 0; i < exp_data.size(); i++) begin
            check($sformatf("addr[%0d]", i), 64'(wr_addr[i]), 64'(exp_addr[i]));
            check($sformatf("data[%0d]", i), wr_data[i], exp_data[i]);
        end
    endtask

    initial begin
        int          r;
        int          len;
        logic [7:0]  pads[3];
        pads[0] = 8'h06;
        pads[1] = 8'h1F;
        pads[2] = 8'h04;

        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check_idle_outputs("reset");

        // rate 17, three full words, then process_i
        for (int i = 0; i < 512; i++) msg_b[i] = 8'($urandom);
        run_msg(17, 17, 8'h06, 24, 1'b1, 1'b0);
        check("t1_addr3",  wr_data[3],  64'h0000_0000_0000_0006);
        check("t1_addr16", wr_data[16], 64'h8000_0000_0000_0000);

        // rate 9, single three-byte word
        msg_b[0] = 8'hef; msg_b[1] = 8'hcd; msg_b[2] = 8'hab;
        run_msg(9, 9, 8'h06, 3, 1'b0, 1'b0);
        check("t2_addr0", wr_data[0], 64'h0000_0000_06ab_cdef);
        check("t2_addr8", wr_data[8], 64'h8000_0000_0000_0000);

        // rate 9, pad byte and end marker share byte 7 of the last word
        run_msg(9, 9, 8'h06, 71, 1'b0, 1'b0);
        check("t3_byte7", 64'(wr_data[8][63:56]), 64'h86);

        // rate 17, exactly one full block, padding spills into a second block
        run_msg(17, 17, 8'h06, 136, 1'b1, 1'b0);
        check("t4_addr0",  wr_data[17], 64'h0000_0000_0000_0006);
        check("t4_addr16", wr_data[33], 64'h8000_0000_0000_0000);

        // illegal rates fall back to the largest rate; ack tied high
        ack_mode = 1;
        run_msg(0, 21, 8'h1F, 13, 1'b0, 1'b0);
        run_msg(25, 21, 8'h04, 168, 1'b0, 1'b0);
        ack_mode = 0;

        // rate 1 with partial word
        run_msg(1, 1, 8'h1F, 5, 1'b1, 1'b0);

        // random messages with backpressure and delayed acks
        for (int m = 0; m < 12; m++) begin
            for (int i = 0; i < 512; i++) msg_b[i] = 8'($urandom);
            r        = $urandom_range(1, 21);
            len      = $urandom_range(0, 2 * r * 8 + 7);
            rdy_mode = $urandom_range(0, 1);
            run_msg(r, r, pads[$urandom_range(0, 2)], len,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        rdy_mode = 0;

        // clear_i while stalled in the pad phase
        mon_en   = 1'b0;
        rdy_mode = 2;
        @(posedge clk_i); #1;
        start_i = 1'b1; rate_words_i = 5'd5; pad_byte_i = 8'h1F;
        @(posedge clk_i); #1;
        start_i = 1'b0; process_i = 1'b1;
        @(posedge clk_i); #1;
        process_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("pad_stall_valid", 64'(keccak_valid_o), 64'd1);
        @(posedge clk_i); #1 clear_i = 1'b1;
        @(posedge clk_i); #1 clear_i = 1'b0;
        @(negedge clk_i);
        check_idle_outputs("clear");
        rdy_mode = 0;
        mon_en   = 1'b1;
        run_msg(5, 5, 8'h06, 17, 1'b0, 1'b0);

        // reset while a word is stalled in absorb
        mon_en   = 1'b0;
        rdy_mode = 2;
        @(posedge clk_i); #1;
        start_i = 1'b1; rate_words_i = 5'd9; pad_byte_i = 8'h06;
        @(posedge clk_i); #1;
        start_i = 1'b0; msg_valid_i = 1'b1; msg_strb_i = 8'hFF; msg_data_i = 64'h1234;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0; msg_valid_i = 1'b0; msg_strb_i = '0;
        @(negedge clk_i);
        check_idle_outputs("rst");
        rdy_mode = 0;
        mon_en   = 1'b1;
        for (int i = 0; i < 512; i++) msg_b[i] = 8'($urandom);
        run_msg(9, 9, 8'h1F, 40, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
